// File: rtl/bitscan_encoder_32to5.sv
// ---------------------------------------------------------------------------
// bitscan_encoder_32to5
//
// Purpose:
//   Takes a 32-bit vector and emits one output beat for each set bit, in
//   priority order. The order is lowest bit first when MSB_FIRST = 0 and
//   highest bit first when MSB_FIRST = 1. Each beat gives the bit index and
//   its one-hot decode. An all-zero vector produces a single beat with
//   out_zero set. Both sides use a valid/ready handshake. A new vector can
//   be accepted in the same cycle as the last beat of the previous one, so
//   back-to-back vectors stream with no bubble.
//
// Parameters:
//   MSB_FIRST   0 = lowest set bit first, 1 = highest set bit first
//
// Ports:
//   clk         input   1   sole clock, rising edge
//   rst_n       input   1   asynchronous active-low reset
//   in_valid    input   1   in_vec is offered
//   in_ready    output  1   block can accept in_vec this cycle
//   in_vec      input  32   bit vector to encode
//   out_valid   output  1   out_* fields are valid
//   out_ready   input   1   consumer takes the current beat
//   out_idx     output  5   index of the current set bit
//   out_onehot  output 32   one-hot decode of out_idx (0 on a zero beat)
//   out_last    output  1   current beat is the final beat of the vector
//   out_zero    output  1   accepted vector was all zeros
// ---------------------------------------------------------------------------
module bitscan_encoder_32to5 #(
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_onehot,
  output logic        out_last,
  output logic        out_zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Index of the lowest set bit. Returns 0 for an all-zero mask.
  function automatic logic [4:0] encodeLow(input logic [31:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Index of the highest set bit. Returns 0 for an all-zero mask.
  function automatic logic [4:0] encodeHigh(input logic [31:0] m);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // Registered state: FSM state, mask of bits not yet emitted, and the
  // registered beat fields.
  state_t      r_state;
  logic [31:0] r_mask;
  logic        r_outValid;
  logic [4:0]  r_outIdx;
  logic [31:0] r_outOnehot;
  logic        r_outLast;
  logic        r_outZero;

  // Next-state values
  state_t      w_nxtState;
  logic [31:0] w_nxtMask;
  logic        w_nxtZero;
  logic [4:0]  w_nxtIdx;
  logic [31:0] w_nxtOnehot;
  logic        w_nxtLast;

  // Handshake qualifiers
  logic        w_accept;
  logic        w_beatTaken;

  // The block is ready when it is idle. It is also ready when the final beat
  // of the current vector is being taken this cycle, because that frees the
  // mask at the same edge the new vector loads into it.
  assign in_ready    = (r_state == IDLE) || ((r_state == SCAN) && out_ready && r_outLast);
  assign w_accept    = in_valid && in_ready;
  assign w_beatTaken = r_outValid && out_ready;

  // Mask update. An accept always takes priority. It can only happen from
  // IDLE or on the last-beat handshake, so it never discards pending bits.
  // A non-last beat clears the emitted bit by using the registered one-hot.
  always_comb begin
    w_nxtState = r_state;
    w_nxtMask  = r_mask;
    w_nxtZero  = r_outZero;
    if (w_accept) begin
      w_nxtState = SCAN;
      w_nxtMask  = in_vec;
      w_nxtZero  = (in_vec == 32'd0);
    end else if ((r_state == SCAN) && w_beatTaken) begin
      if (r_outLast) begin
        w_nxtState = IDLE;
        w_nxtMask  = 32'd0;
        w_nxtZero  = 1'b0;
      end else begin
        w_nxtMask  = r_mask & ~r_outOnehot;
      end
    end
  end

  // Beat fields are computed from the next mask so that they can be
  // registered. When the mask has at most one set bit, clearing its lowest
  // set bit (m & (m-1)) leaves zero, which makes this the final beat.
  always_comb begin
    w_nxtIdx    = (MSB_FIRST != 0) ? encodeHigh(w_nxtMask) : encodeLow(w_nxtMask);
    w_nxtOnehot = (w_nxtMask == 32'd0) ? 32'd0 : (32'd1 << w_nxtIdx);
    w_nxtLast   = ((w_nxtMask & (w_nxtMask - 32'd1)) == 32'd0);
  end

  // Single FSM register block. Reset clears all state. Outside SCAN the
  // beat fields are held at zero, so nothing left over from an earlier
  // vector is visible after reset or after the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mask      <= 32'd0;
      r_outValid  <= 1'b0;
      r_outIdx    <= 5'd0;
      r_outOnehot <= 32'd0;
      r_outLast   <= 1'b0;
      r_outZero   <= 1'b0;
    end else begin
      r_state <= w_nxtState;
      r_mask  <= w_nxtMask;
      if (w_nxtState == SCAN) begin
        r_outValid  <= 1'b1;
        r_outIdx    <= w_nxtIdx;
        r_outOnehot <= w_nxtOnehot;
        r_outLast   <= w_nxtLast;
        r_outZero   <= w_nxtZero;
      end else begin
        r_outValid  <= 1'b0;
        r_outIdx    <= 5'd0;
        r_outOnehot <= 32'd0;
        r_outLast   <= 1'b0;
        r_outZero   <= 1'b0;
      end
    end
  end

  assign out_valid  = r_outValid;
  assign out_idx    = r_outIdx;
  assign out_onehot = r_outOnehot;
  assign out_last   = r_outLast;
  assign out_zero   = r_outZero;

endmodule

// File: tb/tb_bitscan_encoder_32to5.sv
// ---------------------------------------------------------------------------
// tb_bitscan_encoder_32to5
//
// Directed bench for bitscan_encoder_32to5. Two instances share the input
// side: dutL scans lowest bit first (MSB_FIRST=0) and dutH scans highest bit
// first (MSB_FIRST=1). Every test starts with both instances idle. The same
// vector always yields the same number of beats in either order, so both
// instances stay in step and the handshake timing of dutL applies to dutH.
// ---------------------------------------------------------------------------
module tb_bitscan_encoder_32to5;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_vec;
  logic        out_ready;

  logic        lInReady, lOutValid, lOutLast, lOutZero;
  logic [4:0]  lOutIdx;
  logic [31:0] lOutOnehot;

  logic        hInReady, hOutValid, hOutLast, hOutZero;
  logic [4:0]  hOutIdx;
  logic [31:0] hOutOnehot;

  int nVec;
  int nMis;

  bitscan_encoder_32to5 #(.MSB_FIRST(0)) dutL (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(lInReady),
    .in_vec(in_vec), .out_valid(lOutValid), .out_ready(out_ready),
    .out_idx(lOutIdx), .out_onehot(lOutOnehot), .out_last(lOutLast),
    .out_zero(lOutZero)
  );

  bitscan_encoder_32to5 #(.MSB_FIRST(1)) dutH (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(hInReady),
    .in_vec(in_vec), .out_valid(hOutValid), .out_ready(out_ready),
    .out_idx(hOutIdx), .out_onehot(hOutOnehot), .out_last(hOutLast),
    .out_zero(hOutZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move 1 ns past the next rising edge. Outputs are sampled and inputs are
  // driven at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = 32'd0;
    out_ready = 1'b0;
    repeat (2) step();
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL rst_valid got=%b exp=0", lOutValid); end
    nVec++; if (lOutIdx !== 5'd0) begin nMis++; $display("[TB] FAIL rst_idx got=%0d exp=0", lOutIdx); end
    nVec++; if (lOutOnehot !== 32'd0) begin nMis++; $display("[TB] FAIL rst_onehot got=%h exp=0", lOutOnehot); end
    nVec++; if (lOutLast !== 1'b0) begin nMis++; $display("[TB] FAIL rst_last got=%b exp=0", lOutLast); end
    nVec++; if (lOutZero !== 1'b0) begin nMis++; $display("[TB] FAIL rst_zero got=%b exp=0", lOutZero); end
    nVec++; if (lInReady !== 1'b1) begin nMis++; $display("[TB] FAIL rst_inready got=%b exp=1", lInReady); end
    rst_n = 1'b1;
    step();
  endtask

  // V1: 0x8000_0011 scanned LSB first gives idx 0, 4, 31.
  task automatic test_lsb_scan();
    logic [4:0]  expIdx [3];
    logic [31:0] expHot [3];
    expIdx = '{5'd0, 5'd4, 5'd31};
    expHot = '{32'h0000_0001, 32'h0000_0010, 32'h8000_0000};
    out_ready = 1'b1;
    in_vec    = 32'h8000_0011;
    in_valid  = 1'b1;
    #1;
    nVec++; if (lInReady !== 1'b1) begin nMis++; $display("[TB] FAIL v1_accept_ready got=%b exp=1", lInReady); end
    step();
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nVec++; if (lOutValid !== 1'b1) begin nMis++; $display("[TB] FAIL v1_valid beat=%0d got=%b exp=1", i, lOutValid); end
      nVec++; if (lOutIdx !== expIdx[i]) begin nMis++; $display("[TB] FAIL v1_idx beat=%0d got=%0d exp=%0d", i, lOutIdx, expIdx[i]); end
      nVec++; if (lOutOnehot !== expHot[i]) begin nMis++; $display("[TB] FAIL v1_onehot beat=%0d got=%h exp=%h", i, lOutOnehot, expHot[i]); end
      nVec++; if (lOutLast !== (i == 2)) begin nMis++; $display("[TB] FAIL v1_last beat=%0d got=%b exp=%b", i, lOutLast, (i == 2)); end
      nVec++; if (lInReady !== (i == 2)) begin nMis++; $display("[TB] FAIL v1_inready beat=%0d got=%b exp=%b", i, lInReady, (i == 2)); end
      step();
    end
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v1_idle_valid got=%b exp=0", lOutValid); end
  endtask

  // V2: all-zero vector gives a single zero beat, then the block is idle.
  task automatic test_zero_vector();
    out_ready = 1'b1;
    in_vec    = 32'h0000_0000;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    nVec++; if (lOutValid !== 1'b1) begin nMis++; $display("[TB] FAIL v2_valid got=%b exp=1", lOutValid); end
    nVec++; if (lOutZero !== 1'b1) begin nMis++; $display("[TB] FAIL v2_zero got=%b exp=1", lOutZero); end
    nVec++; if (lOutIdx !== 5'd0) begin nMis++; $display("[TB] FAIL v2_idx got=%0d exp=0", lOutIdx); end
    nVec++; if (lOutOnehot !== 32'd0) begin nMis++; $display("[TB] FAIL v2_onehot got=%h exp=0", lOutOnehot); end
    nVec++; if (lOutLast !== 1'b1) begin nMis++; $display("[TB] FAIL v2_last got=%b exp=1", lOutLast); end
    step();
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v2_idle_valid got=%b exp=0", lOutValid); end
    nVec++; if (lInReady !== 1'b1) begin nMis++; $display("[TB] FAIL v2_idle_ready got=%b exp=1", lInReady); end
  endtask

  // V3: backpressure on 0x6. A competing vector is offered while in_ready=0
  // and must be ignored.
  task automatic test_backpressure();
    out_ready = 1'b0;
    in_vec    = 32'h0000_0006;
    in_valid  = 1'b1;
    step();
    in_vec = 32'hFFFF_0000;
    #1;
    for (int c = 0; c < 3; c++) begin
      nVec++; if (lOutValid !== 1'b1) begin nMis++; $display("[TB] FAIL v3_hold_valid cyc=%0d got=%b exp=1", c, lOutValid); end
      nVec++; if (lOutIdx !== 5'd1) begin nMis++; $display("[TB] FAIL v3_hold_idx cyc=%0d got=%0d exp=1", c, lOutIdx); end
      nVec++; if (lOutOnehot !== 32'h2) begin nMis++; $display("[TB] FAIL v3_hold_onehot cyc=%0d got=%h exp=2", c, lOutOnehot); end
      nVec++; if (lInReady !== 1'b0) begin nMis++; $display("[TB] FAIL v3_hold_ready cyc=%0d got=%b exp=0", c, lInReady); end
      if (c < 2) step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    nVec++; if (lOutIdx !== 5'd2) begin nMis++; $display("[TB] FAIL v3_idx2 got=%0d exp=2", lOutIdx); end
    nVec++; if (lOutLast !== 1'b1) begin nMis++; $display("[TB] FAIL v3_last got=%b exp=1", lOutLast); end
    nVec++; if (lOutOnehot !== 32'h4) begin nMis++; $display("[TB] FAIL v3_onehot2 got=%h exp=4", lOutOnehot); end
    step();
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v3_idle_valid got=%b exp=0", lOutValid); end
  endtask

  // V4: 0x1 followed by 0xFFFF_FFFF, with the second vector accepted on
  // the single-beat last handshake and streaming out 32 beats with no gap.
  task automatic test_back_to_back();
    logic [31:0] hot;
    out_ready = 1'b1;
    in_vec    = 32'h0000_0001;
    in_valid  = 1'b1;
    step();
    in_vec = 32'hFFFF_FFFF;
    #1;
    nVec++; if ((lOutIdx !== 5'd0) || (lOutLast !== 1'b1) || (lOutValid !== 1'b1)) begin
      nMis++; $display("[TB] FAIL v4_first valid=%b idx=%0d last=%b exp valid=1 idx=0 last=1", lOutValid, lOutIdx, lOutLast);
    end
    nVec++; if (lInReady !== 1'b1) begin nMis++; $display("[TB] FAIL v4_ready_on_last got=%b exp=1", lInReady); end
    step();
    for (int i = 0; i < 32; i++) begin
      hot = 32'd1 << i;
      if (i == 31) begin
        in_valid = 1'b0;
        #1;
      end
      nVec++; if ((lOutValid !== 1'b1) || (lOutIdx !== 5'(i)) || (lOutOnehot !== hot) || (lOutLast !== (i == 31)) || (lOutZero !== 1'b0)) begin
        nMis++; $display("[TB] FAIL v4_beat beat=%0d got valid=%b idx=%0d hot=%h last=%b zero=%b exp valid=1 idx=%0d hot=%h last=%b zero=0",
                         i, lOutValid, lOutIdx, lOutOnehot, lOutLast, lOutZero, i, hot, (i == 31));
      end
      step();
    end
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v4_idle_valid got=%b exp=0", lOutValid); end
  endtask

  // V5: reset in the middle of the scan of 0xF0 discards bits 6 and 7.
  task automatic test_midscan_reset();
    out_ready = 1'b1;
    in_vec    = 32'h0000_00F0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    #1;
    nVec++; if (lOutIdx !== 5'd4) begin nMis++; $display("[TB] FAIL v5_idx4 got=%0d exp=4", lOutIdx); end
    step();
    nVec++; if (lOutIdx !== 5'd5) begin nMis++; $display("[TB] FAIL v5_idx5 got=%0d exp=5", lOutIdx); end
    step();
    rst_n = 1'b0;
    #1;
    nVec++; if (lOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v5_async_valid got=%b exp=0", lOutValid); end
    nVec++; if (lInReady !== 1'b1) begin nMis++; $display("[TB] FAIL v5_async_ready got=%b exp=1", lInReady); end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      nVec++; if ((lOutValid !== 1'b0) || (lInReady !== 1'b1)) begin
        nMis++; $display("[TB] FAIL v5_post_reset cyc=%0d valid=%b ready=%b exp valid=0 ready=1", c, lOutValid, lInReady);
      end
    end
  endtask

  // V6: MSB-first instance scans 0x8000_0011 as idx 31, 4, 0.
  task automatic test_msb_scan();
    logic [4:0]  expIdx [3];
    logic [31:0] expHot [3];
    expIdx = '{5'd31, 5'd4, 5'd0};
    expHot = '{32'h8000_0000, 32'h0000_0010, 32'h0000_0001};
    out_ready = 1'b1;
    in_vec    = 32'h8000_0011;
    in_valid  = 1'b1;
    #1;
    nVec++; if (hInReady !== 1'b1) begin nMis++; $display("[TB] FAIL v6_accept_ready got=%b exp=1", hInReady); end
    step();
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      nVec++; if ((hOutValid !== 1'b1) || (hOutIdx !== expIdx[i]) || (hOutOnehot !== expHot[i]) || (hOutLast !== (i == 2))) begin
        nMis++; $display("[TB] FAIL v6_beat beat=%0d got valid=%b idx=%0d hot=%h last=%b exp valid=1 idx=%0d hot=%h last=%b",
                         i, hOutValid, hOutIdx, hOutOnehot, hOutLast, expIdx[i], expHot[i], (i == 2));
      end
      step();
    end
    nVec++; if (hOutValid !== 1'b0) begin nMis++; $display("[TB] FAIL v6_idle_valid got=%b exp=0", hOutValid); end
  endtask

  initial begin
    nVec = 0;
    nMis = 0;
    test_reset();
    test_lsb_scan();
    test_zero_vector();
    test_backpressure();
    test_back_to_back();
    test_midscan_reset();
    test_msb_scan();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/bitscan_encoder_32to5.md
BITSCAN_ENCODER_32TO5 -- requirements
Module: bitscan_encoder_32to5

Interface
REQ-001 SHALL provide parameter: MSB_FIRST, default 0, scan order; 0 = lowest set bit first, 1 = highest set bit first.
REQ-002 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port: in_valid  input  1  in_vec offered.
REQ-005 SHALL provide port: in_ready  output  1  block can accept in_vec this cycle.
REQ-006 SHALL provide port: in_vec  input  32  bit vector to encode.
REQ-007 SHALL provide port: out_valid  output  1  out_* fields valid.
REQ-008 SHALL provide port: out_ready  input  1  consumer takes the current beat.
REQ-009 SHALL provide port: out_idx  output  5  index of the current set bit.
REQ-010 SHALL provide port: out_onehot  output  32  one-hot decode of out_idx; 0 on a zero beat.
REQ-011 SHALL provide port: out_last  output  1  current beat is the final beat of the vector.
REQ-012 SHALL provide port: out_zero  output  1  accepted vector was all zeros.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SCAN.
REQ-014 SHALL hold a 32-bit mask register of bits not yet emitted.
REQ-015 SHALL accept a vector when in_valid && in_ready.
- On accept: mask <= in_vec and state <= SCAN.
- out_valid SHALL rise the cycle after accept (1-cycle latency).
REQ-016 In SCAN, out_valid SHALL be 1.
- out_idx SHALL be the priority-encoded index of mask: lowest set bit if MSB_FIRST=0, highest if MSB_FIRST=1.
REQ-017 out_last SHALL be 1 when mask has at most one set bit.
REQ-018 For an all-zero accepted vector, SHALL emit exactly one beat: out_zero=1, out_idx=0, out_onehot=0, out_last=1.
REQ-019 On out_valid && out_ready && !out_last, SHALL clear bit out_idx in mask and stay in SCAN.
REQ-020 On out_valid && out_ready && out_last, state SHALL go to IDLE unless a new vector is accepted in the same cycle (REQ-022).
REQ-021 While out_valid && !out_ready, all out_* fields SHALL hold stable.
REQ-022 in_ready SHALL equal (state==IDLE) || (state==SCAN && out_ready && out_last).
- A simultaneous last-beat handshake and accept SHALL load the new mask and remain in SCAN with no bubble cycle.
REQ-023 A vector with N set bits (N>=1) SHALL produce exactly N beats with strictly monotonic out_idx; a zero vector SHALL produce 1 beat.
REQ-024 in_vec SHALL be ignored whenever in_ready=0.
REQ-025 out_onehot SHALL always equal 1<<out_idx when out_zero=0.

Reset
REQ-026 While rst_n=0, SHALL asynchronously force: state=IDLE, mask=0, out_valid=0, out_idx=0, out_onehot=0, out_last=0, out_zero=0, in_ready=1.
REQ-027 Reset asserted mid-scan SHALL discard all remaining bits; no beat SHALL be emitted after rst_n rises until a new accept occurs.

Verification
REQ-028 A bench SHALL cover the following directed scenarios:
- V1: MSB_FIRST=0, in_vec=0x8000_0011, out_ready=1 -> beats idx 0,4,31; onehot 0x1, 0x10, 0x8000_0000; out_last only on idx 31; first beat 1 cycle after accept; in_ready=0 during beats 1-2.
- V2: in_vec=0x0000_0000 -> one beat: out_zero=1, out_idx=0, out_onehot=0, out_last=1; then IDLE.
- V3: in_vec=0x0000_0006, out_ready=0 for 3 cycles -> out_idx=1 and out_onehot=0x2 held stable 3 cycles; then idx 2 with out_last=1.
- V4: in_vec=0x0000_0001, then in_vec=0xFFFF_FFFF held valid -> second vector accepted on the idx-0 last beat; 32 consecutive beats idx 0..31 follow with no gap.
- V5: in_vec=0x0000_00F0; after beats 4,5, drive rst_n=0 -> out_valid=0 immediately; after release, in_ready=1 and no beats for idx 6 or 7.
- V6: MSB_FIRST=1, in_vec=0x8000_0011 -> beats idx 31,4,0; out_last on idx 0.
